// File: rtl/grid_mem_arbiter_pkg.sv
// Shared constants and encodings for the playfield occupancy RAM arbiter.
package grid_mem_arbiter_pkg;

  localparam int GRID_W     = 80;
  localparam int GRID_H     = 60;
  localparam int CELL_W     = 2;
  localparam int ADDR_W     = 13;
  localparam int GRID_CELLS = GRID_W * GRID_H;

  typedef enum logic [CELL_W-1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  // Who owns the RAM read data arriving this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_REN  = 2'd1,
    OWN_CORE = 2'd2
  } owner_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// Bundle of clear, renderer, core and RAM-side signals around the arbiter.
interface grid_mem_arbiter_if;
  import grid_mem_arbiter_pkg::*;

  logic              clr_req;
  logic              clr_busy;
  logic              ren_en;
  logic [7:0]        ren_gx;
  logic [6:0]        ren_gy;
  logic [CELL_W-1:0] ren_data;
  logic              ren_valid;
  logic              core_req;
  logic              core_we;
  logic [7:0]        core_gx;
  logic [6:0]        core_gy;
  logic [CELL_W-1:0] core_wdata;
  logic              core_ack;
  logic [CELL_W-1:0] core_rdata;
  logic              core_oob;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] mem_rdata;

  modport slave (
    input  clr_req, ren_en, ren_gx, ren_gy,
    input  core_req, core_we, core_gx, core_gy, core_wdata,
    input  mem_rdata,
    output clr_busy, ren_data, ren_valid,
    output core_ack, core_rdata, core_oob,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output clr_req, ren_en, ren_gx, ren_gy,
    output core_req, core_we, core_gx, core_gy, core_wdata,
    output mem_rdata,
    input  clr_busy, ren_data, ren_valid,
    input  core_ack, core_rdata, core_oob,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/grid_mem_arbiter_addr_map.sv
// Combinational grid coordinate to RAM address mapping with range flag.
module grid_addr_map
  import grid_mem_arbiter_pkg::*;
#(
  parameter int GW = GRID_W,
  parameter int GH = GRID_H,
  parameter int AW = ADDR_W
) (
  input  logic [7:0]    i_gx,
  input  logic [6:0]    i_gy,
  output logic [AW-1:0] o_addr,
  output logic          o_oob
);

  localparam logic [7:0] GX_LIM = 8'(GW);
  localparam logic [6:0] GY_LIM = 7'(GH);

  logic [AW-1:0] w_gx_ext;
  logic [AW-1:0] w_gy_ext;

  assign w_gx_ext = AW'(i_gx);
  assign w_gy_ext = AW'(i_gy);

  // 80 = 64 + 16, so the row offset is two shifted copies of gy.
  generate
    if (GW == 80) begin : g_shift
      assign o_addr = (w_gy_ext << 6) + (w_gy_ext << 4) + w_gx_ext;
    end else begin : g_mul
      assign o_addr = w_gy_ext * AW'(GW) + w_gx_ext;
    end
  endgenerate

  assign o_oob = (i_gx >= GX_LIM) | (i_gy >= GY_LIM);

endmodule

// File: rtl/grid_mem_arbiter.sv
// Single-port occupancy RAM arbiter: clear sweep, renderer reads, core read/modify/write.
module grid_mem_arbiter
  import grid_mem_arbiter_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst_n,
  grid_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_CELLS - 1);

  state_t            r_state, w_state_next;
  owner_t            r_tag, w_tag_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr_last;
  logic [CELL_W-1:0] r_wdata_last;
  logic              r_ren_valid;
  logic              r_core_ack;
  logic              r_core_oob;

  logic              w_mem_en, w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [CELL_W-1:0] w_mem_wdata;

  // Index 0 maps the renderer, index 1 maps the core.
  logic [7:0]        w_gx       [2];
  logic [6:0]        w_gy       [2];
  logic [ADDR_W-1:0] w_map_addr [2];
  logic              w_map_oob  [2];

  assign w_gx[0] = bus.ren_gx;
  assign w_gy[0] = bus.ren_gy;
  assign w_gx[1] = bus.core_gx;
  assign w_gy[1] = bus.core_gy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_map
      grid_addr_map u_map (
        .i_gx   (w_gx[gi]),
        .i_gy   (w_gy[gi]),
        .o_addr (w_map_addr[gi]),
        .o_oob  (w_map_oob[gi])
      );
    end
  endgenerate

  logic w_ren_rd, w_core_grant, w_core_acc;

  assign w_ren_rd     = (r_state == ST_RUN) & bus.ren_en & ~w_map_oob[0];
  // The core may not be re-granted in the cycle its previous access is acked.
  assign w_core_grant = (r_state == ST_RUN) & ~bus.ren_en & bus.core_req & ~r_core_ack;
  assign w_core_acc   = w_core_grant & ~w_map_oob[1];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tag_next   = OWN_NONE;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_addr_last;
    w_mem_wdata  = r_wdata_last;
    case (r_state)
      ST_CLEAR: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cnt;
        w_mem_wdata = '0;
        if (r_cnt == LAST_ADDR) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (w_ren_rd) begin
          w_mem_en   = 1'b1;
          w_mem_addr = w_map_addr[0];
          w_tag_next = OWN_REN;
        end else if (w_core_acc) begin
          w_mem_en    = 1'b1;
          w_mem_we    = bus.core_we;
          w_mem_addr  = w_map_addr[1];
          w_mem_wdata = bus.core_wdata;
          w_tag_next  = bus.core_we ? OWN_NONE : OWN_CORE;
        end
      end
      default: w_state_next = ST_CLEAR;
    endcase
    if (bus.clr_req) begin
      w_state_next = ST_CLEAR;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_tag        <= OWN_NONE;
      r_addr_last  <= '0;
      r_wdata_last <= '0;
      r_ren_valid  <= 1'b0;
      r_core_ack   <= 1'b0;
      r_core_oob   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_tag       <= w_tag_next;
      r_ren_valid <= bus.ren_en;
      r_core_ack  <= w_core_grant;
      r_core_oob  <= w_core_grant & w_map_oob[1];
      if (w_mem_en) begin
        r_addr_last  <= w_mem_addr;
        r_wdata_last <= w_mem_wdata;
      end
    end
  end

  assign bus.clr_busy   = (r_state == ST_CLEAR);
  assign bus.ren_valid  = r_ren_valid;
  assign bus.ren_data   = (r_tag == OWN_REN) ? bus.mem_rdata : '0;
  assign bus.core_ack   = r_core_ack;
  assign bus.core_oob   = r_core_oob;
  assign bus.core_rdata = (r_tag == OWN_CORE) ? bus.mem_rdata : '0;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a behavioural single-port RAM.
module tb_grid_mem_arbiter;
  import grid_mem_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  grid_mem_arbiter_if bus ();

  grid_mem_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM preloaded with non-zero cells so the clear sweep is observable.
  logic [1:0] ram [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] <= 2'd1;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at posedge+1 of the first sweep cycle, returns at the negedge of the first RUN cycle.
  task automatic sweep(output int busy, output int bad);
    busy = 0;
    bad  = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (!bus.clr_busy) break;
      if (!(bus.mem_en && bus.mem_we && int'(bus.mem_addr) == busy && bus.mem_wdata == 2'd0)) bad++;
      if (bus.core_ack) bad++;
      busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_inputs();
    bus.clr_req = 0; bus.ren_en = 0; bus.ren_gx = 0; bus.ren_gy = 0;
    bus.core_req = 0; bus.core_we = 0; bus.core_gx = 0; bus.core_gy = 0; bus.core_wdata = 0;
  endtask

  typedef struct {
    bit ren; int rgx; int rgy;
    bit creq; bit cwe; int cgx; int cgy; int cwd;
    bit e_en; bit e_we; int e_addr;
    bit e_rv; int e_rd;
    bit e_ack; int e_crd; bit e_oob;
  } vec_t;

  vec_t vecs [16];
  int   shadow [8192];

  initial begin
    int busy, bad, k, exp_addr, n;
    int start, prev_addr, c_addr, c_wd;
    bit active, prev_ren, c_we, ren;

    errors = 0;
    checks = 0;
    for (int i = 0; i < 8192; i++) shadow[i] = 0;

    //              ren  rgx rgy  creq we cgx cgy wd            en we addr   rv rd  ack crd oob
    vecs[0]  = '{1'b1, 79, 59, 1'b0, 1'b0,  0, 0, 0,          1'b1, 1'b0, 4799, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0,  0,  0, 1'b0, 1'b0,  0, 0, 0,          1'b0, 1'b0, 4799, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b0,  0,  0, 1'b1, 1'b1,  5, 2, CELL_FOOD,  1'b1, 1'b1,  165, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[3]  = '{1'b0,  0,  0, 1'b1, 1'b1,  5, 2, CELL_FOOD,  1'b0, 1'b0,  165, 1'b0, 0, 1'b1, 0, 1'b0};
    vecs[4]  = '{1'b0,  0,  0, 1'b1, 1'b0,  5, 2, 0,          1'b1, 1'b0,  165, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b0,  0,  0, 1'b1, 1'b0,  5, 2, 0,          1'b0, 1'b0,  165, 1'b0, 0, 1'b1, 3, 1'b0};
    vecs[6]  = '{1'b1,  0,  0, 1'b1, 1'b1, 10, 1, CELL_HEAD,  1'b1, 1'b0,    0, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[7]  = '{1'b0,  0,  0, 1'b1, 1'b1, 10, 1, CELL_HEAD,  1'b1, 1'b1,   90, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[8]  = '{1'b0,  0,  0, 1'b1, 1'b1, 10, 1, CELL_HEAD,  1'b0, 1'b0,   90, 1'b0, 0, 1'b1, 0, 1'b0};
    vecs[9]  = '{1'b1, 10,  1, 1'b0, 1'b0,  0, 0, 0,          1'b1, 1'b0,   90, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[10] = '{1'b0,  0,  0, 1'b0, 1'b0,  0, 0, 0,          1'b0, 1'b0,   90, 1'b1, 2, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0,  0,  0, 1'b1, 1'b0, 80, 0, 0,          1'b0, 1'b0,   90, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[12] = '{1'b0,  0,  0, 1'b1, 1'b0, 80, 0, 0,          1'b0, 1'b0,   90, 1'b0, 0, 1'b1, 0, 1'b1};
    vecs[13] = '{1'b1,  0, 60, 1'b0, 1'b0,  0, 0, 0,          1'b0, 1'b0,   90, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[14] = '{1'b1,  5,  2, 1'b0, 1'b0,  0, 0, 0,          1'b1, 1'b0,  165, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[15] = '{1'b0,  0,  0, 1'b0, 1'b0,  0, 0, 0,          1'b0, 1'b0,  165, 1'b1, 3, 1'b0, 0, 1'b0};

    // Reset with a renderer strobe pending; nothing may leak through.
    rst_n = 1'b0;
    idle_inputs();
    bus.ren_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ren_valid", int'(bus.ren_valid), 0);
    chk("rst_core_ack", int'(bus.core_ack), 0);
    chk("rst_core_oob", int'(bus.core_oob), 0);
    chk("rst_clr_busy", int'(bus.clr_busy), 1);
    chk("rst_ren_data", int'(bus.ren_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ren_en = 1'b0;
    sweep(busy, bad);
    chk("sweep_busy_cycles", busy, 4800);
    chk("sweep_addr_seq", bad, 0);
    $display("sweep: busy=%0d bad=%0d", busy, bad);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.ren_en     = vecs[i].ren;
      bus.ren_gx     = 8'(vecs[i].rgx);
      bus.ren_gy     = 7'(vecs[i].rgy);
      bus.core_req   = vecs[i].creq;
      bus.core_we    = vecs[i].cwe;
      bus.core_gx    = 8'(vecs[i].cgx);
      bus.core_gy    = 7'(vecs[i].cgy);
      bus.core_wdata = 2'(vecs[i].cwd);
      @(negedge clk);
      chk($sformatf("v%0d_mem_en", i), int'(bus.mem_en), int'(vecs[i].e_en));
      chk($sformatf("v%0d_mem_we", i), int'(bus.mem_we), int'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), int'(bus.mem_addr), vecs[i].e_addr);
      chk($sformatf("v%0d_ren_valid", i), int'(bus.ren_valid), int'(vecs[i].e_rv));
      chk($sformatf("v%0d_ren_data", i), int'(bus.ren_data), vecs[i].e_rd);
      chk($sformatf("v%0d_core_ack", i), int'(bus.core_ack), int'(vecs[i].e_ack));
      chk($sformatf("v%0d_core_rdata", i), int'(bus.core_rdata), vecs[i].e_crd);
      chk($sformatf("v%0d_core_oob", i), int'(bus.core_oob), int'(vecs[i].e_oob));
      $display("vec %0d: mem_en=%0d addr=%0d ren_valid=%0d ren_data=%0d ack=%0d rdata=%0d oob=%0d",
               i, bus.mem_en, bus.mem_addr, bus.ren_valid, bus.ren_data,
               bus.core_ack, bus.core_rdata, bus.core_oob);
    end

    // Renderer on alternate cycles against a continuous core request stream.
    active = 0; prev_ren = 0; prev_addr = 0; start = 0; c_addr = 0; c_we = 0; c_wd = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      ren = (cyc % 2 == 0);
      bus.ren_en = ren;
      bus.ren_gx = 8'($urandom_range(3));
      bus.ren_gy = 7'($urandom_range(3));
      if (!active && cyc < 195) begin
        bus.core_gx    = 8'($urandom_range(3));
        bus.core_gy    = 7'($urandom_range(3));
        c_we           = 1'($urandom_range(1));
        c_wd           = $urandom_range(3);
        bus.core_we    = c_we;
        bus.core_wdata = 2'(c_wd);
        bus.core_req   = 1'b1;
        c_addr         = int'(bus.core_gy) * GRID_W + int'(bus.core_gx);
        active         = 1;
        start          = cyc;
      end else if (!active) begin
        bus.core_req = 1'b0;
      end
      @(negedge clk);
      chk("alt_ren_valid", int'(bus.ren_valid), int'(prev_ren));
      if (prev_ren) chk("alt_ren_data", int'(bus.ren_data), shadow[prev_addr]);
      prev_ren  = ren;
      prev_addr = int'(bus.ren_gy) * GRID_W + int'(bus.ren_gx);
      if (bus.core_ack) begin
        chk("alt_ack_latency_ok", int'((cyc - start) >= 1 && (cyc - start) <= 3), 1);
        if (!c_we) chk("alt_core_rdata", int'(bus.core_rdata), shadow[c_addr]);
        else       shadow[c_addr] = c_wd;
        $display("stream ack: addr=%0d we=%0d lat=%0d rdata=%0d", c_addr, c_we, cyc - start, bus.core_rdata);
        active = 0;
      end else if (active && (cyc - start) > 3) begin
        chk("alt_ack_timeout", cyc - start, 3);
        active = 0;
      end
    end

    // Clear request from RUN, restart at 1000, reset at 2000, with a core read held pending.
    @(posedge clk); #1;
    idle_inputs();
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk("clrreq_run_busy", int'(bus.clr_busy), 0);
    @(posedge clk); #1;
    bus.clr_req  = 1'b0;
    bus.core_req = 1'b1;
    bus.core_we  = 1'b0;
    bus.core_gx  = 8'd5;
    bus.core_gy  = 7'd2;
    @(negedge clk);
    chk("clr_start_busy", int'(bus.clr_busy), 1);
    chk("clr_start_addr", int'(bus.mem_addr), 0);

    for (int target = 1000; target <= 2000; target += 1000) begin
      exp_addr = 0; bad = 0; n = 0;
      while (int'(bus.mem_addr) != target && n < 2500) begin
        if (int'(bus.mem_addr) != exp_addr || bus.core_ack || !bus.clr_busy) bad++;
        exp_addr++;
        n++;
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk($sformatf("seq_to_%0d", target), bad, 0);
      chk($sformatf("reach_%0d", target), int'(bus.mem_addr), target);
      if (target == 1000) begin
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        bus.clr_req = 1'b0;
        @(negedge clk);
        chk("clr_restart_addr", int'(bus.mem_addr), 0);
        $display("clr_req at 1000: addr now %0d", bus.mem_addr);
      end else begin
        rst_n      = 1'b0;
        bus.ren_en = 1'b1;
        @(posedge clk); #1;
        bus.ren_en = 1'b0;
        @(negedge clk);
        chk("rstmid_ren_valid", int'(bus.ren_valid), 0);
        chk("rstmid_core_ack", int'(bus.core_ack), 0);
        chk("rstmid_clr_busy", int'(bus.clr_busy), 1);
        chk("rstmid_addr", int'(bus.mem_addr), 0);
        $display("reset at 2000: addr now %0d", bus.mem_addr);
      end
    end

    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(busy, bad);
    chk("resweep_busy_cycles", busy, 4800);
    chk("resweep_addr_seq", bad, 0);
    k = 0;
    while (!bus.core_ack && k < 4) begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end
    chk("pend_ack_seen", int'(bus.core_ack), 1);
    chk("pend_ack_latency", k, 1);
    chk("pend_rdata_cleared", int'(bus.core_rdata), 0);
    $display("pending read: ack after %0d cycles rdata=%0d", k, bus.core_rdata);

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
